// File: rtl/uart_alu_host.sv
// Initiator side of the UART operand/result protocol: sends A, B and the opcode
// over a byte-level TX port, then waits for one result byte on RX with a timeout.
module uart_alu_host #(
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [DBIT-1:0] i_a,
  input  logic [DBIT-1:0] i_b,
  input  logic [DBIT-1:0] i_op,
  output logic            o_tx_start,
  output logic [DBIT-1:0] o_tx_data,
  input  logic            i_tx_done_tick,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_rx_done_tick,
  output logic            o_busy,
  output logic [DBIT-1:0] o_result,
  output logic            o_valid,
  output logic            o_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    WAIT_A,
    SEND_B,
    WAIT_B,
    SEND_OP,
    WAIT_OP,
    WAIT_RES
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [DBIT-1:0]   a_q;
  logic [DBIT-1:0]   b_q;
  logic [DBIT-1:0]   op_q;
  logic [TO_W-1:0]   cnt_q;
  logic              tx_start_q;
  logic [DBIT-1:0]   tx_data_q;
  logic              busy_q;
  logic [DBIT-1:0]   result_q;
  logic              valid_q;
  logic              timeout_q;

  // busy_q is updated alongside every state transition so it always mirrors
  // (state_q != IDLE) while remaining a plain register output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_b;
            op_q    <= i_op;
            busy_q  <= 1'b1;
            state_q <= SEND_A;
          end
        end

        SEND_A: begin
          tx_data_q  <= a_q;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_A;
        end

        WAIT_A: begin
          if (i_tx_done_tick) state_q <= SEND_B;
        end

        SEND_B: begin
          tx_data_q  <= b_q;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_B;
        end

        WAIT_B: begin
          if (i_tx_done_tick) state_q <= SEND_OP;
        end

        SEND_OP: begin
          tx_data_q  <= op_q;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_OP;
        end

        WAIT_OP: begin
          if (i_tx_done_tick) begin
            cnt_q   <= '0;
            state_q <= WAIT_RES;
          end
        end

        // A result arriving on the expiry cycle takes priority over the timeout.
        WAIT_RES: begin
          if (i_rx_done_tick) begin
            result_q <= i_rx_data;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else if (cnt_q == TO_LAST) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_result   = result_q;
  assign o_valid    = valid_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_host.sv
// Scoreboard bench for uart_alu_host: expected TX bytes and result events are
// queued as stimulus is driven and popped as the DUT emits them.
module tb_uart_alu_host;

  localparam int DBIT = 8;

  logic            clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_start = 1'b0;
  logic [DBIT-1:0] i_a = '0;
  logic [DBIT-1:0] i_b = '0;
  logic [DBIT-1:0] i_op = '0;
  logic            o_tx_start;
  logic [DBIT-1:0] o_tx_data;
  logic            i_tx_done_tick = 1'b0;
  logic [DBIT-1:0] i_rx_data = '0;
  logic            i_rx_done_tick = 1'b0;
  logic            o_busy;
  logic [DBIT-1:0] o_result;
  logic            o_valid;
  logic            o_timeout;

  int checks = 0;
  int errors = 0;

  logic [DBIT-1:0] exp_tx[$];
  logic [DBIT:0]   exp_res[$];   // {is_timeout, result}

  logic            prev_tx_start = 1'b0;
  logic            prev_busy     = 1'b0;
  logic [DBIT-1:0] prev_tx_data  = '0;

  always #5 clk = ~clk;

  uart_alu_host #(
    .DBIT    (DBIT),
    .TIMEOUT (50),
    .TO_W    (6)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_a            (i_a),
    .i_b            (i_b),
    .i_op           (i_op),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .i_tx_done_tick (i_tx_done_tick),
    .i_rx_data      (i_rx_data),
    .i_rx_done_tick (i_rx_done_tick),
    .o_busy         (o_busy),
    .o_result       (o_result),
    .o_valid        (o_valid),
    .o_timeout      (o_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: TX bytes and result events against the scoreboard.
  always @(negedge clk) begin
    if (o_tx_start) begin
      chk("tx_pulse_len", 32'(prev_tx_start), 32'd0);
      if (exp_tx.size() == 0) chk("tx_unexpected", 32'd1, 32'd0);
      else begin
        logic [DBIT-1:0] e;
        e = exp_tx.pop_front();
        chk("tx_data", 32'(o_tx_data), 32'(e));
      end
    end else if (prev_busy && o_busy) begin
      chk("tx_hold", 32'(o_tx_data), 32'(prev_tx_data));
    end
    if (o_valid || o_timeout) begin
      chk("valid_xor_timeout", 32'(o_valid & o_timeout), 32'd0);
      if (exp_res.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
      else begin
        logic [DBIT:0] r;
        r = exp_res.pop_front();
        chk("res_kind", 32'(o_timeout), 32'(r[DBIT]));
        chk("res_value", 32'(o_result), 32'(r[DBIT-1:0]));
      end
    end
    prev_tx_start = o_tx_start;
    prev_busy     = o_busy;
    prev_tx_data  = o_tx_data;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_req(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    i_start = 1'b1;
    i_a = a;
    i_b = b;
    i_op = op;
    exp_tx.push_back(a);
    exp_tx.push_back(b);
    exp_tx.push_back(op);
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_rise", 32'(o_busy), 32'd1);
    chk("tx_start_early", 32'(o_tx_start), 32'd0);
    @(negedge clk);
    chk("tx_start_latency", 32'(o_tx_start), 32'd1);
  endtask

  task automatic wait_tx();
    int k = 0;
    while (!o_tx_start && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("tx_start_wait", 32'd0, 32'd1);
  endtask

  task automatic pulse_done(input int gap);
    tick(gap);
    i_tx_done_tick = 1'b1;
    @(negedge clk);
    i_tx_done_tick = 1'b0;
  endtask

  task automatic byte_done(input int gap);
    wait_tx();
    pulse_done(gap);
  endtask

  task automatic rx_send(input logic [7:0] val, input int delay);
    tick(delay);
    i_rx_data = val;
    i_rx_done_tick = 1'b1;
    exp_res.push_back({1'b0, val});
    @(negedge clk);
    i_rx_done_tick = 1'b0;
    chk("valid_pulse", 32'(o_valid), 32'd1);
    chk("result", 32'(o_result), 32'(val));
    chk("busy_drop", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("valid_len", 32'(o_valid), 32'd0);
    chk("result_hold", 32'(o_result), 32'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    tick(3);
    chk("reset_outputs",
        32'({o_busy, o_tx_start, o_tx_data, o_result, o_valid, o_timeout}), 32'd0);
    i_reset = 1'b0;
    tick(2);

    // Normal transaction
    start_req(8'h05, 8'h03, 8'h20);
    byte_done(2);
    byte_done(3);
    byte_done(1);
    rx_send(8'h08, 5);
    chk("idle_tx_data_retained", 32'(o_tx_data), 32'h20);

    // Timeout: result byte never arrives
    tick(2);
    exp_res.push_back({1'b1, 8'h08});
    start_req(8'h11, 8'h22, 8'h33);
    byte_done(1);
    byte_done(1);
    byte_done(2);
    k = 0;
    while (!o_timeout && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", 32'(k), 32'd50);
    chk("timeout_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("timeout_len", 32'(o_timeout), 32'd0);
    chk("timeout_result_kept", 32'(o_result), 32'h08);

    // Stray RX byte while waiting for A's tx-done
    tick(1);
    start_req(8'h01, 8'h02, 8'h03);
    wait_tx();
    i_rx_data = 8'hAA;
    i_rx_done_tick = 1'b1;
    @(negedge clk);
    i_rx_done_tick = 1'b0;
    chk("stray_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("stray_result", 32'(o_result), 32'h08);
    pulse_done(1);
    byte_done(1);
    byte_done(1);
    rx_send(8'h11, 4);

    // Start request during WAIT_B is ignored
    start_req(8'h41, 8'h42, 8'h43);
    byte_done(1);
    wait_tx();
    i_start = 1'b1;
    i_a = 8'hFF;
    @(negedge clk);
    i_start = 1'b0;
    pulse_done(1);
    byte_done(1);
    rx_send(8'h55, 2);
    tick(8);
    chk("no_second_txn_busy", 32'(o_busy), 32'd0);
    chk("no_second_txn_tx", 32'(exp_tx.size()), 32'd0);

    // Reset in WAIT_B
    start_req(8'h0A, 8'h0B, 8'h0C);
    byte_done(1);
    wait_tx();
    tick(1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    chk("midrst_outputs",
        32'({o_busy, o_tx_start, o_tx_data, o_result, o_valid, o_timeout}), 32'd0);
    exp_tx.delete();
    tick(2);
    chk("midrst_still_idle", 32'(o_busy), 32'd0);
    start_req(8'h07, 8'h08, 8'h09);
    byte_done(1);
    byte_done(1);
    byte_done(1);
    rx_send(8'h0F, 3);

    // rx-done on the expiry cycle, then back-to-back start
    start_req(8'h21, 8'h22, 8'h23);
    byte_done(1);
    byte_done(1);
    byte_done(1);
    tick(49);
    i_rx_data = 8'h3C;
    i_rx_done_tick = 1'b1;
    exp_res.push_back({1'b0, 8'h3C});
    @(negedge clk);
    i_rx_done_tick = 1'b0;
    chk("coinc_valid", 32'(o_valid), 32'd1);
    chk("coinc_timeout", 32'(o_timeout), 32'd0);
    chk("coinc_result", 32'(o_result), 32'h3C);
    start_req(8'h61, 8'h62, 8'h63);
    byte_done(1);
    byte_done(1);
    byte_done(1);
    rx_send(8'h7E, 3);

    tick(5);
    chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    chk("res_queue_drained", 32'(exp_res.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
